// File: rtl/dmem_lsu.sv
// Data memory / peripheral load-store unit for the RV32 core: RAM, output
// registers and synchronised inputs behind a valid/ready request/response port.
module dmem_lsu #(
  parameter int unsigned RAM_AW   = 11,
  parameter int unsigned N_OUT    = 16,
  parameter int unsigned N_IN     = 4,
  parameter logic [31:0] OUT_BASE = 32'h0000_7000,
  parameter logic [31:0] IN_BASE  = 32'h0000_7800
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_unsigned_i,
  input  logic [31:0]         req_addr_i,
  input  logic [31:0]         req_wdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_err_o,
  input  logic [32*N_IN-1:0]  io_in_i,
  output logic [32*N_OUT-1:0] io_out_o
);
  localparam int unsigned RAM_WORDS = 2 ** (RAM_AW - 2);

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state_q;
  logic [31:0] mem     [RAM_WORDS];
  logic [31:0] out_q   [N_OUT];
  logic [31:0] sync1_q [N_IN];
  logic [31:0] sync2_q [N_IN];

  logic [31:0] ram_rd_q, io_rd_q;
  logic        src_ram_q, ld_q, err_q, uns_q;
  logic [1:0]  size_q, off_q;

  logic              accept;
  logic              hit_ram, hit_out, hit_in, misaligned, err_d;
  logic              wr_ram, wr_out;
  logic [5:0]        widx;
  logic [1:0]        off;
  logic [RAM_AW-3:0] ridx;
  logic [3:0]        be;
  logic [31:0]       wrep, io_word, rd_word;

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] size,
                                              input logic uns);
    logic [31:0] r;
    case (size)
      2'b00:   r = uns ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      2'b01:   r = uns ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign req_ready_o = (state_q == IDLE) | rsp_ready_i;
  assign rsp_valid_o = (state_q == RESP);
  assign accept      = rst_ni & req_valid_i & req_ready_o;

  assign widx = req_addr_i[7:2];
  assign off  = req_addr_i[1:0];
  assign ridx = req_addr_i[RAM_AW-1:2];

  // RAM takes priority should a peripheral window ever fall inside it
  assign hit_ram = (req_addr_i[31:RAM_AW] == '0);
  assign hit_out = !hit_ram && (req_addr_i[31:8] == OUT_BASE[31:8]) && ({26'd0, widx} < N_OUT);
  assign hit_in  = !hit_ram && !hit_out && (req_addr_i[31:8] == IN_BASE[31:8])
                   && ({26'd0, widx} < N_IN);

  assign misaligned = (req_size_i == 2'b11) || (req_size_i == 2'b01 && off[0])
                      || (req_size_i == 2'b10 && off != 2'b00);
  assign err_d  = misaligned || !(hit_ram || hit_out || hit_in) || (req_we_i && hit_in);
  assign wr_ram = accept && req_we_i && !err_d && hit_ram;
  assign wr_out = accept && req_we_i && !err_d && hit_out;

  always_comb begin
    be   = 4'b0000;
    wrep = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        be   = 4'b0001 << off;
        wrep = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        be   = off[1] ? 4'b1100 : 4'b0011;
        wrep = {2{req_wdata_i[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    io_word = '0;
    for (int k = 0; k < int'(N_OUT); k++)
      if (hit_out && widx == 6'(k)) io_word = out_q[k];
    for (int k = 0; k < int'(N_IN); k++)
      if (hit_in && widx == 6'(k)) io_word = sync2_q[k];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_q <= RESP;
        default: if (!accept && rsp_ready_i) state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(N_IN); k++) begin
        sync1_q[k] <= '0;
        sync2_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(N_IN); k++) begin
        sync1_q[k] <= io_in_i[32*k +: 32];
        sync2_q[k] <= sync1_q[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(N_OUT); k++) out_q[k] <= '0;
    end else begin
      for (int k = 0; k < int'(N_OUT); k++) begin
        if (wr_out && widx == 6'(k)) begin
          if (be[0]) out_q[k][7:0]   <= wrep[7:0];
          if (be[1]) out_q[k][15:8]  <= wrep[15:8];
          if (be[2]) out_q[k][23:16] <= wrep[23:16];
          if (be[3]) out_q[k][31:24] <= wrep[31:24];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ram) begin
      if (be[0]) mem[ridx][7:0]   <= wrep[7:0];
      if (be[1]) mem[ridx][15:8]  <= wrep[15:8];
      if (be[2]) mem[ridx][23:16] <= wrep[23:16];
      if (be[3]) mem[ridx][31:24] <= wrep[31:24];
    end
    if (accept) ram_rd_q <= mem[ridx];
  end

  // Accept edge: capture everything the response needs; held until next accept
  always_ff @(posedge clk_i) begin
    if (accept) begin
      src_ram_q <= hit_ram;
      ld_q      <= !req_we_i && !err_d;
      err_q     <= err_d;
      size_q    <= req_size_i;
      off_q     <= off;
      uns_q     <= req_unsigned_i;
      io_rd_q   <= io_word;
    end
  end

  assign rd_word     = (src_ram_q ? ram_rd_q : io_rd_q) >> {off_q, 3'b000};
  assign rsp_rdata_o = (rsp_valid_o && ld_q) ? load_extend(rd_word, size_q, uns_q) : '0;
  assign rsp_err_o   = rsp_valid_o && err_q;

  for (genvar k = 0; k < int'(N_OUT); k++) begin : g_out
    assign io_out_o[32*k +: 32] = out_q[k];
  end

endmodule
